mngr_src_sink: RTL and testbench
================================

# mngr_src_sink

Synthesizable test manager for the processor's manager streaming ports, on the opposite side from the core. It streams preloaded 32-bit words into `mngr2proc` and checks each `proc2mngr` word in order against a preloaded expected table. It reports pass/fail with the first-mismatch details. It replaces the behavioural manager interface in FPGA and self-checking builds; delay parameters model slow source/sink behaviour.

## Interface
- `p_depth`, 64: entries per table (source and expected).
- `p_src_delay`, 0: idle cycles inserted after each source transfer.
- `p_sink_delay`, 0: cycles `proc2mngr_rdy` is held low after each accepted word.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `ld_en`  in  1  table write strobe; honoured only in IDLE.
- `ld_sel`  in  1  0 = source table, 1 = expected table.
- `ld_addr`  in  AW=$clog2(p_depth)  table write address.
- `ld_data`  in  32  table write data.
- `cfg_num_src` / `cfg_num_sink`  in  CW=$clog2(p_depth+1)  message counts, latched on `start`.
- `start`  in  1  begin run; honoured only in IDLE.
- `mngr2proc_msg`  out  32; `mngr2proc_val`  out  1; `mngr2proc_rdy`  in  1.
- `proc2mngr_msg`  in  32; `proc2mngr_val`  in  1; `proc2mngr_rdy`  out  1.
- `done`  out  1  run finished (PASS or FAIL), sticky until reset or next start.
- `pass`  out  1  all expected words matched.
- `err_idx`  out  CW  index of first mismatching word.
- `err_got` / `err_exp`  out  32  received vs expected word at `err_idx`.

## Operation
- Top FSM: IDLE -> RUN on `start`. RUN -> PASS when sink count reaches `cfg_num_sink`. RUN -> FAIL on the first mismatch. PASS/FAIL -> RUN on `start`, which clears `done`, `pass` and the error registers.
- Source: independent pointer `src_i`.
  - `mngr2proc_val` = RUN && `src_i` < num_src && src delay counter == 0.
  - `mngr2proc_msg` = src_table[`src_i`], driven combinationally from the pointer.
  - On val&&rdy: `src_i`++, delay counter loads `p_src_delay`.
  - `msg` is stable while val is high and rdy is low.
- Sink: pointer `snk_i`.
  - `proc2mngr_rdy` = RUN && `snk_i` < num_sink && sink delay counter == 0.
  - On val&&rdy: compare with exp_table[`snk_i`].
    - Equal: `snk_i`++, delay loads `p_sink_delay`.
    - Unequal: capture `err_idx`=`snk_i`, `err_got`, `err_exp`; go to FAIL.
- The source continues streaming in PASS/FAIL only until the state leaves RUN. Both val and rdy are 0 outside RUN.
- Counts larger than `p_depth` saturate to `p_depth` when latched.
- `ld_en`/`start` outside IDLE are ignored, except `start` in PASS/FAIL.
- Tables hold their contents across runs; reset does not clear them.

## Timing
- Reset values:
  - state IDLE; pointers and delay counters 0.
  - `done`=0, `pass`=0, `err_idx`=0, `err_got`=0, `err_exp`=0.
  - `mngr2proc_val`=0, `proc2mngr_rdy`=0.
- `start` at edge N: `mngr2proc_val` and `proc2mngr_rdy` may be high in cycle N+1.
- Throughput with delay 0: one transfer per cycle per direction.
- Throughput with delay D: one transfer per D+1 cycles.
- Compare is registered at the accepting edge. `done`/`pass` or the error outputs are visible the cycle after the final or mismatching transfer.
- `cfg_num_sink`=0: PASS (`done`=`pass`=1) in cycle N+1, with no sink transfers.
- A mismatch and the last source transfer in the same cycle: both take effect, and FAIL wins.
- Reset asserted mid-run: all outputs return to reset values at the next edge, and in-flight words are dropped.
- A table write and a read of the same address in the same cycle cannot occur, because writes happen only in IDLE.

## Structure
- Package `mngr_pkg`:
  - `mngr_state_e` (IDLE, RUN, PASS, FAIL).
  - `MNGR_MSG_W`=32.
  - helper function for saturating the count.
- Sub-module `mngr_table`: `p_depth` x 32 storage with one synchronous write port and one combinational read port. It is instantiated twice (source and expected).
- The delay counters and pointers stay inline in `mngr_src_sink`.

## Test plan
- Load src {5, 7}, exp {12}, counts 2/1. Bench sink adds its two inputs and returns 12 -> `done`=1, `pass`=1 one cycle after acceptance.
- exp {1,2,3}; bench returns 1, 9, 3 -> FAIL with `err_idx`=1, `err_got`=9, `err_exp`=2; `proc2mngr_rdy`=0 afterwards, and the third word is never accepted.
- `p_src_delay`=2, 4 source words, `mngr2proc_rdy` held 1 -> val pulses on cycles N+1, N+4, N+7, N+10.
- `mngr2proc_rdy` low for 5 cycles while val=1 -> `msg` is unchanged throughout, and `src_i` advances only on the rdy cycle.
- `cfg_num_sink`=0, `cfg_num_src`=0 -> `pass`=1 at N+1 with no val/rdy activity; a second `start` clears and then re-asserts `pass`.
- `rst`=0 for one cycle mid-run after 3 of 8 transfers -> all outputs 0. `start` then reruns from index 0 with the tables intact and passes.

Source files
------------

// File: rtl/mngr_pkg.sv
// Shared types and helpers for the manager source/sink test block.
package mngr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } mngr_state_e;

  localparam int MNGR_MSG_W = 32;

  // Message counts above the table depth are clamped to the depth.
  function automatic int sat_count(input int cnt, input int depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/mngr_table.sv
// Word table: p_depth x p_width storage, one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read is same-cycle from the address.
// Backpressure: none; the caller owns write/read ordering.
module mngr_table #(
  parameter int p_depth = 64,
  parameter int p_width = 32,
  localparam int AW = $clog2(p_depth)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [p_width-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [p_width-1:0] rd_data
);

  // Contents are intentionally not reset so tables survive across runs and resets.
  logic [p_width-1:0] mem [p_depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mngr_src_sink.sv
// Manager-side test harness: streams the source table into mngr2proc, checks proc2mngr against the expected table.
// Latency: val/rdy may rise the cycle after start; done/pass/err visible the cycle after the final or mismatching transfer.
// Backpressure: source holds msg stable while rdy is low; sink deasserts rdy for p_sink_delay cycles after each accept.
module mngr_src_sink
  import mngr_pkg::*;
#(
  parameter int p_depth      = 64,
  parameter int p_src_delay  = 0,
  parameter int p_sink_delay = 0,
  localparam int AW = $clog2(p_depth),
  localparam int CW = $clog2(p_depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_en,
  input  logic                  ld_sel,
  input  logic [AW-1:0]         ld_addr,
  input  logic [MNGR_MSG_W-1:0] ld_data,
  input  logic [CW-1:0]         cfg_num_src,
  input  logic [CW-1:0]         cfg_num_sink,
  input  logic                  start,
  output logic [MNGR_MSG_W-1:0] mngr2proc_msg,
  output logic                  mngr2proc_val,
  input  logic                  mngr2proc_rdy,
  input  logic [MNGR_MSG_W-1:0] proc2mngr_msg,
  input  logic                  proc2mngr_val,
  output logic                  proc2mngr_rdy,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         err_idx,
  output logic [MNGR_MSG_W-1:0] err_got,
  output logic [MNGR_MSG_W-1:0] err_exp
);

  localparam int DW = 16;

  mngr_state_e           state_q, state_d;
  logic [CW-1:0]         num_src, num_snk, src_i, snk_i;
  logic [CW-1:0]         start_nsrc, start_nsnk;
  logic [DW-1:0]         src_dly, snk_dly;
  logic [MNGR_MSG_W-1:0] src_rd, exp_rd;
  logic                  run, start_ok, src_fire, snk_fire, mismatch, snk_last;

  assign start_nsrc = CW'(sat_count(int'(cfg_num_src), p_depth));
  assign start_nsnk = CW'(sat_count(int'(cfg_num_sink), p_depth));

  assign run      = (state_q == RUN);
  assign start_ok = start && !run;

  assign mngr2proc_val = run && (src_i < num_src) && (src_dly == '0);
  assign proc2mngr_rdy = run && (snk_i < num_snk) && (snk_dly == '0);
  assign mngr2proc_msg = src_rd;

  assign src_fire = mngr2proc_val && mngr2proc_rdy;
  assign snk_fire = proc2mngr_val && proc2mngr_rdy;
  assign mismatch = snk_fire && (proc2mngr_msg != exp_rd);
  assign snk_last = (snk_i == num_snk - CW'(1));

  mngr_table #(.p_depth(p_depth), .p_width(MNGR_MSG_W)) u_src_tbl (
    .clk     (clk),
    .wr_en   (ld_en && (state_q == IDLE) && !ld_sel),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (src_i[AW-1:0]),
    .rd_data (src_rd)
  );

  mngr_table #(.p_depth(p_depth), .p_width(MNGR_MSG_W)) u_exp_tbl (
    .clk     (clk),
    .wr_en   (ld_en && (state_q == IDLE) && ld_sel),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (snk_i[AW-1:0]),
    .rd_data (exp_rd)
  );

  always_comb begin
    state_d = state_q;
    done    = (state_q == PASS) || (state_q == FAIL);
    pass    = (state_q == PASS);
    case (state_q)
      RUN: begin
        if (mismatch) begin
          state_d = FAIL;
        end else if (snk_fire && snk_last) begin
          state_d = PASS;
        end
      end
      // An empty sink run has nothing to check, so it passes immediately.
      default: begin
        if (start_ok) begin
          state_d = (start_nsnk == '0) ? PASS : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      num_src <= '0;
      num_snk <= '0;
      src_i   <= '0;
      snk_i   <= '0;
      src_dly <= '0;
      snk_dly <= '0;
      err_idx <= '0;
      err_got <= '0;
      err_exp <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_src <= start_nsrc;
        num_snk <= start_nsnk;
        src_i   <= '0;
        snk_i   <= '0;
        src_dly <= '0;
        snk_dly <= '0;
        err_idx <= '0;
        err_got <= '0;
        err_exp <= '0;
      end else begin
        if (src_fire) begin
          src_i   <= src_i + CW'(1);
          src_dly <= DW'(p_src_delay);
        end else if (src_dly != '0) begin
          src_dly <= src_dly - DW'(1);
        end
        if (mismatch) begin
          err_idx <= snk_i;
          err_got <= proc2mngr_msg;
          err_exp <= exp_rd;
        end else if (snk_fire) begin
          snk_i   <= snk_i + CW'(1);
          snk_dly <= DW'(p_sink_delay);
        end else if (snk_dly != '0) begin
          snk_dly <= snk_dly - DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mngr_src_sink.sv
// Bench for mngr_src_sink: emulates the processor side and predicts outcomes from table/return-word lists.
module tb_mngr_src_sink;

  localparam int DEPTH = 8;
  localparam int SD    = 2;
  localparam int KD    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  cfg_num_src = '0, cfg_num_sink = '0;
  logic        start = 1'b0;
  logic [31:0] mngr2proc_msg;
  logic        mngr2proc_val;
  logic        mngr2proc_rdy = 1'b0;
  logic [31:0] proc2mngr_msg = '0;
  logic        proc2mngr_val = 1'b0;
  logic        proc2mngr_rdy;
  logic        done, pass;
  logic [3:0]  err_idx;
  logic [31:0] err_got, err_exp;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_m [DEPTH];
  logic [31:0] exp_m [DEPTH];
  logic [31:0] got_src [$];
  logic [31:0] ret_q [$];
  int          src_cyc [$];
  int          acc_n, done_cyc, cyc;

  mngr_src_sink #(.p_depth(DEPTH), .p_src_delay(SD), .p_sink_delay(KD)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_en         (ld_en),
    .ld_sel        (ld_sel),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .cfg_num_src   (cfg_num_src),
    .cfg_num_sink  (cfg_num_sink),
    .start         (start),
    .mngr2proc_msg (mngr2proc_msg),
    .mngr2proc_val (mngr2proc_val),
    .mngr2proc_rdy (mngr2proc_rdy),
    .proc2mngr_msg (proc2mngr_msg),
    .proc2mngr_val (proc2mngr_val),
    .proc2mngr_rdy (proc2mngr_rdy),
    .done          (done),
    .pass          (pass),
    .err_idx       (err_idx),
    .err_got       (err_got),
    .err_exp       (err_exp)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; ld_en = 1'b0;
    mngr2proc_rdy = 1'b0; proc2mngr_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'(i); ld_data = src_m[i];
      @(negedge clk);
      ld_sel = 1'b1; ld_data = exp_m[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rand_tables();
    for (int i = 0; i < DEPTH; i++) begin
      src_m[i] = $urandom;
      exp_m[i] = $urandom;
    end
  endtask

  // Leaves the bench at the falling edge of the first cycle after the start edge (cycle 1).
  task automatic do_start(input int ns, input int nk);
    @(negedge clk);
    cfg_num_src = 4'(ns); cfg_num_sink = 4'(nk); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_src.delete(); src_cyc.delete(); ret_q.delete();
    acc_n = 0; done_cyc = -1; cyc = 1;
  endtask

  // Processor emulation: consume source words, offer queued return words, stop on done.
  task automatic pump(input int max_cyc, input bit sum_mode, input bit rand_rdy, input int max_acc);
    for (int k = 0; k < max_cyc; k++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (acc_n >= max_acc) break;
      mngr2proc_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      proc2mngr_val = (ret_q.size() > 0);
      proc2mngr_msg = proc2mngr_val ? ret_q[0] : 32'h0;
      if (proc2mngr_val && proc2mngr_rdy) begin
        void'(ret_q.pop_front());
        acc_n++;
      end
      if (mngr2proc_val && mngr2proc_rdy) begin
        got_src.push_back(mngr2proc_msg);
        src_cyc.push_back(cyc);
        if (sum_mode && got_src.size() == 2) ret_q.push_back(got_src[0] + got_src[1]);
      end
      @(negedge clk);
      cyc++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    mngr2proc_rdy = 1'b0;
    proc2mngr_val = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (mngr2proc_val !== 1'b0) begin errors++; $display("FAIL rst_val got %0b exp 0", mngr2proc_val); end
    checks++; if (proc2mngr_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %0b exp 0", proc2mngr_rdy); end
    checks++; if ({done, pass} !== 2'b00) begin errors++; $display("FAIL rst_done_pass got %b exp 00", {done, pass}); end
    checks++; if ({err_idx, err_got, err_exp} !== '0) begin errors++; $display("FAIL rst_err got %0h/%0h/%0h exp 0", err_idx, err_got, err_exp); end
    rst = 1'b1;
  endtask

  task automatic test_sum();
    do_reset();
    rand_tables();
    src_m[0] = 32'd5; src_m[1] = 32'd7; exp_m[0] = 32'd12;
    load_all();
    do_start(2, 1);
    pump(100, 1'b1, 1'b0, 99);
    checks++; if (got_src.size() != 2 || got_src[0] !== 32'd5 || got_src[1] !== 32'd7) begin errors++; $display("FAIL sum_src got %0d words exp 5,7", got_src.size()); end
    checks++; if (src_cyc.size() != 2 || src_cyc[1] != 1 + (SD + 1)) begin errors++; $display("FAIL sum_src_cyc got %0d exp %0d", src_cyc.size() == 2 ? src_cyc[1] : -1, 1 + (SD + 1)); end
    // Sum offered the cycle after the second source word, accepted that cycle, result one cycle later.
    checks++; if (done_cyc != 1 + (SD + 1) + 2) begin errors++; $display("FAIL sum_done_cyc got %0d exp %0d", done_cyc, 1 + (SD + 1) + 2); end
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL sum_pass got %b exp 11", {done, pass}); end
  endtask

  task automatic test_mismatch();
    do_reset();
    rand_tables();
    exp_m[0] = 32'd1; exp_m[1] = 32'd2; exp_m[2] = 32'd3;
    load_all();
    do_start(3, 3);
    ret_q = '{32'd1, 32'd9, 32'd3};
    pump(100, 1'b0, 1'b0, 99);
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL mm_state got %b exp 10", {done, pass}); end
    checks++; if (err_idx !== 4'd1 || err_got !== 32'd9 || err_exp !== 32'd2) begin errors++; $display("FAIL mm_err got %0d/%0d/%0d exp 1/9/2", err_idx, err_got, err_exp); end
    // Word 0 at cycle 1, sink gap of KD cycles, word 1 at cycle 2+KD, verdict the next cycle.
    checks++; if (done_cyc != 3 + KD) begin errors++; $display("FAIL mm_done_cyc got %0d exp %0d", done_cyc, 3 + KD); end
    checks++; if (acc_n != 2 || ret_q.size() != 1) begin errors++; $display("FAIL mm_accepted got %0d exp 2", acc_n); end
    proc2mngr_val = 1'b1; proc2mngr_msg = 32'd3;
    for (int k = 0; k < 4; k++) begin
      checks++; if (proc2mngr_rdy !== 1'b0) begin errors++; $display("FAIL mm_rdy_after got %0b exp 0", proc2mngr_rdy); end
      @(negedge clk);
    end
    proc2mngr_val = 1'b0;
  endtask

  task automatic test_src_delay();
    do_start(4, 1);
    pump(11, 1'b0, 1'b0, 99);
    checks++; if (src_cyc.size() != 4) begin errors++; $display("FAIL dly_count got %0d exp 4", src_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < src_cyc.size()) begin
        checks++; if (src_cyc[i] != 1 + i * (SD + 1) || got_src[i] !== src_m[i]) begin errors++; $display("FAIL dly_pulse%0d got cyc %0d exp %0d", i, src_cyc[i], 1 + i * (SD + 1)); end
      end
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dly_early_done got %0b exp 0", done); end
    ret_q.push_back(exp_m[0]);
    pump(50, 1'b0, 1'b0, 99);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL dly_pass got %0b exp 1", pass); end
  endtask

  task automatic test_backpressure();
    do_start(2, 1);
    mngr2proc_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (mngr2proc_val !== 1'b1 || mngr2proc_msg !== src_m[0]) begin errors++; $display("FAIL bp_hold got %0b/%0h exp 1/%0h", mngr2proc_val, mngr2proc_msg, src_m[0]); end
      @(negedge clk);
    end
    mngr2proc_rdy = 1'b1;
    checks++; if (mngr2proc_val !== 1'b1 || mngr2proc_msg !== src_m[0]) begin errors++; $display("FAIL bp_take got %0b/%0h exp 1/%0h", mngr2proc_val, mngr2proc_msg, src_m[0]); end
    @(negedge clk);
    for (int k = 0; k < SD; k++) begin
      checks++; if (mngr2proc_val !== 1'b0) begin errors++; $display("FAIL bp_gap got %0b exp 0", mngr2proc_val); end
      @(negedge clk);
    end
    checks++; if (mngr2proc_val !== 1'b1 || mngr2proc_msg !== src_m[1]) begin errors++; $display("FAIL bp_next got %0b/%0h exp 1/%0h", mngr2proc_val, mngr2proc_msg, src_m[1]); end
    ret_q.push_back(exp_m[0]);
    pump(50, 1'b0, 1'b0, 99);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL bp_pass got %0b exp 1", pass); end
  endtask

  task automatic test_zero();
    logic [31:0] bad;
    do_start(1, 1);
    bad = exp_m[0] ^ 32'hA5A5_0001;
    ret_q.push_back(bad);
    pump(50, 1'b0, 1'b0, 99);
    checks++; if ({done, pass} !== 2'b10 || err_got !== bad) begin errors++; $display("FAIL zero_setup got %b/%0h exp 10/%0h", {done, pass}, err_got, bad); end
    for (int r = 0; r < 2; r++) begin
      do_start(0, 0);
      checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL zero_pass%0d got %b exp 11", r, {done, pass}); end
      checks++; if ({err_idx, err_got, err_exp} !== '0) begin errors++; $display("FAIL zero_err_clr%0d got %0h/%0h exp 0", r, err_got, err_exp); end
      for (int k = 0; k < 3; k++) begin
        checks++; if ({mngr2proc_val, proc2mngr_rdy} !== 2'b00) begin errors++; $display("FAIL zero_idle%0d got %b exp 00", r, {mngr2proc_val, proc2mngr_rdy}); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_saturate();
    do_start(15, 15);
    for (int i = 0; i < DEPTH; i++) ret_q.push_back(exp_m[i]);
    pump(300, 1'b0, 1'b1, 99);
    checks++; if ({done, pass} !== 2'b11 || acc_n != DEPTH) begin errors++; $display("FAIL sat_pass got %b acc %0d exp 11 acc %0d", {done, pass}, acc_n, DEPTH); end
    checks++; if (got_src.size() > DEPTH) begin errors++; $display("FAIL sat_src_count got %0d exp <=%0d", got_src.size(), DEPTH); end
    for (int i = 0; i < got_src.size() && i < DEPTH; i++) begin
      checks++; if (got_src[i] !== src_m[i]) begin errors++; $display("FAIL sat_src%0d got %0h exp %0h", i, got_src[i], src_m[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int ns, nk, bad_i;
      logic [31:0] ret [DEPTH];
      do_reset();
      rand_tables();
      load_all();
      ns = $urandom_range(0, DEPTH);
      nk = $urandom_range(0, DEPTH);
      bad_i = -1;
      for (int i = 0; i < nk; i++) ret[i] = exp_m[i];
      if (nk > 0 && $urandom_range(0, 1) == 1) begin
        bad_i = $urandom_range(0, nk - 1);
        ret[bad_i] = exp_m[bad_i] ^ (32'($urandom) | 32'h1);
      end
      do_start(ns, nk);
      for (int i = 0; i < nk; i++) ret_q.push_back(ret[i]);
      pump(400, 1'b0, 1'b1, 99);
      if (bad_i < 0) begin
        checks++; if ({done, pass} !== 2'b11 || acc_n != nk) begin errors++; $display("FAIL rnd%0d_pass got %b acc %0d exp 11 acc %0d", it, {done, pass}, acc_n, nk); end
      end else begin
        checks++; if ({done, pass} !== 2'b10 || acc_n != bad_i + 1) begin errors++; $display("FAIL rnd%0d_fail got %b acc %0d exp 10 acc %0d", it, {done, pass}, acc_n, bad_i + 1); end
        checks++; if (err_idx !== 4'(bad_i) || err_got !== ret[bad_i] || err_exp !== exp_m[bad_i]) begin errors++; $display("FAIL rnd%0d_err got %0d/%0h/%0h exp %0d/%0h/%0h", it, err_idx, err_got, err_exp, bad_i, ret[bad_i], exp_m[bad_i]); end
      end
      if (nk == 0) begin
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL rnd%0d_empty_cyc got %0d exp 1", it, done_cyc); end
      end
      checks++; if (got_src.size() > ns) begin errors++; $display("FAIL rnd%0d_src_count got %0d exp <=%0d", it, got_src.size(), ns); end
      for (int i = 0; i < got_src.size() && i < DEPTH; i++) begin
        checks++; if (got_src[i] !== src_m[i]) begin errors++; $display("FAIL rnd%0d_src%0d got %0h exp %0h", it, i, got_src[i], src_m[i]); end
      end
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    rand_tables();
    load_all();
    do_start(8, 8);
    for (int i = 0; i < DEPTH; i++) ret_q.push_back(exp_m[i]);
    pump(100, 1'b0, 1'b0, 3);
    checks++; if (acc_n != 3 || done !== 1'b0) begin errors++; $display("FAIL mr_progress got acc %0d done %0b exp 3/0", acc_n, done); end
    // Writes while running must not reach the tables.
    ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = ~src_m[0];
    @(negedge clk);
    ld_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({mngr2proc_val, proc2mngr_rdy, done, pass} !== 4'b0000) begin errors++; $display("FAIL mr_ctl got %b exp 0000", {mngr2proc_val, proc2mngr_rdy, done, pass}); end
    checks++; if ({err_idx, err_got, err_exp} !== '0) begin errors++; $display("FAIL mr_err got %0h/%0h/%0h exp 0", err_idx, err_got, err_exp); end
    rst = 1'b1;
    do_start(8, 8);
    for (int i = 0; i < DEPTH; i++) ret_q.push_back(exp_m[i]);
    pump(300, 1'b0, 1'b0, 99);
    checks++; if ({done, pass} !== 2'b11 || acc_n != DEPTH) begin errors++; $display("FAIL mr_rerun got %b acc %0d exp 11 acc %0d", {done, pass}, acc_n, DEPTH); end
    checks++; if (got_src.size() < 1) begin errors++; $display("FAIL mr_src_count got %0d exp >=1", got_src.size()); end
    for (int i = 0; i < got_src.size() && i < DEPTH; i++) begin
      checks++; if (got_src[i] !== src_m[i]) begin errors++; $display("FAIL mr_src%0d got %0h exp %0h", i, got_src[i], src_m[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_mismatch();
    test_src_delay();
    test_backpressure();
    test_zero();
    test_saturate();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
